muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide instructions in the EX stage of the 5-stage RV32I core. It accepts one operation from the ALU issue path and runs an iterative shift-add (multiply) or restoring shift-subtract (divide) over 32 cycles. During that time it holds the pipeline stalled. It then presents a single-cycle `done` pulse with the 32-bit result for writeback. The single-cycle ALU is unchanged; this block runs in parallel to it and is selected only for funct7 = 0000001 OP instructions.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 23 ++
 rtl/muldiv_seq.sv | 210 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, widths and state type for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  // funct3 encodings of the M-extension OP instructions
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Divide/remainder ops all have funct3[2] set
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational add/subtract step with carry out (carry = no-borrow when subtracting).
module muldiv_step #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_res_c,
  output logic         o_cout_c
);

  logic [W-1:0] w_b;
  logic [W:0]   w_sum;

  // a + b, or a + ~b + 1 for subtraction
  always_comb begin
    w_b      = i_sub ? ~i_b : i_b;
    w_sum    = {1'b0, i_a} + {1'b0, w_b} + (W+1)'(i_sub);
    o_res_c  = w_sum[W-1:0];
    o_cout_c = w_sum[W];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add / restoring divide,
// sign fix-up, single-cycle done pulse. Stalls the pipeline via busy.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SW = XLEN + 1;

  muldiv_state_t r_state;
  muldiv_state_t w_state_nxt;

  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_opb;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  logic             w_accept;
  logic             w_s1;
  logic             w_s2;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_val;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [SW-1:0]    w_step_a;
  logic [SW-1:0]    w_step_b;
  logic             w_step_sub;
  logic [SW-1:0]    w_step_res;
  logic             w_step_cout;

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_val;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // Issue decode: operand signedness, magnitudes and the divide special cases
  always_comb begin
    w_accept = (r_state == IDLE) && start && !flush;
    w_s1 = 1'b0;
    w_s2 = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        w_s1 = rs1[XLEN-1];
        w_s2 = rs2[XLEN-1];
      end
      OP_MULHSU: w_s1 = rs1[XLEN-1];
      default: ;
    endcase
    w_mag1 = w_s1 ? -rs1 : rs1;
    w_mag2 = w_s2 ? -rs2 : rs2;
    w_div_zero = op_is_div(op) && (rs2 == '0);
    w_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    w_special  = w_div_zero || w_div_ovf;
    if (w_div_zero) begin
      w_special_val = ((op == OP_REM) || (op == OP_REMU)) ? rs1 : '1;
    end else begin
      w_special_val = ((op == OP_REM) || (op == OP_REMU)) ? '0 : rs1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush wins over everything including start
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) w_state_nxt = w_special ? DONE : CALC;
        CALC: if (r_cnt == '0) w_state_nxt = FIX;
        FIX:  w_state_nxt = DONE;
        DONE: w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state (registered below)
  always_comb begin
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // Step operand select: multiply adds multiplicand when lo[0]; divide trial-subtracts
  always_comb begin
    w_step_sub = op_is_div(r_op);
    if (w_step_sub) begin
      w_step_a = {r_hi, r_lo[XLEN-1]};
      w_step_b = {1'b0, r_opb};
    end else begin
      w_step_a = {1'b0, r_hi};
      w_step_b = r_lo[0] ? {1'b0, r_opb} : '0;
    end
  end

  muldiv_step #(
    .W (SW)
  ) u_step (
    .i_a      (w_step_a),
    .i_b      (w_step_b),
    .i_sub    (w_step_sub),
    .o_res_c  (w_step_res),
    .o_cout_c (w_step_cout)
  );

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    w_prod     = {r_hi, r_lo};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quo_fix  = r_neg_q ? -r_lo : r_lo;
    w_rem_fix  = r_neg_r ? -r_hi : r_hi;
    case (r_op)
      OP_MUL:                        w_fix_val = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix_val = w_quo_fix;
      OP_REM, OP_REMU:               w_fix_val = w_rem_fix;
      default:                       w_fix_val = '0;
    endcase
  end

  // Operand load on issue and one shift-add / shift-subtract per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op    <= op;
      r_neg_q <= w_s1 ^ w_s2;
      r_neg_r <= w_s1;
      r_cnt   <= CNT_W'(XLEN - 1);
      r_hi    <= '0;
      if (op_is_div(op)) begin
        r_lo  <= w_mag1;
        r_opb <= w_mag2;
      end else begin
        r_lo  <= w_mag2;
        r_opb <= w_mag1;
      end
    end else if (r_state == CALC) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      if (!op_is_div(r_op)) begin
        r_hi <= w_step_res[SW-1:1];
        r_lo <= {w_step_res[0], r_lo[XLEN-1:1]};
      end else if (w_step_cout) begin
        r_hi <= w_step_res[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], 1'b1};
      end else begin
        r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        r_lo <= {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Registered outputs; result changes only on a special-case issue or a completed FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept && w_special) begin
        r_result <= w_special_val;
      end else if ((r_state == FIX) && !flush) begin
        r_result <= w_fix_val;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, busy/done timing, flush and reset.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] rs1   = '0;
  logic [31:0] rs2   = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int dc;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, keep start high for 'hold' cycles after the accepting edge,
  // then measure latency to done, check busy stayed high and the result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    int  n;
    logic busy_ok;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (n >= hold) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!busy) busy_ok = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " busy held"}, 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " result hold"}, result, exp_res);
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply family
    run_op("MUL 7*-3",        OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    run_op("MULH min*min",    OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    run_op("MULHU max*max",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    run_op("MULHSU -1*2",     OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 0);

    // Divide special cases finish one cycle after issue
    run_op("DIV by zero",     OP_DIV,    32'h12345678, 32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("REMU by zero",    OP_REMU,   32'd5,        32'd0,        32'd5,        1, 0);
    run_op("DIV overflow",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("REM overflow",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    // Regular divides
    run_op("REM -7%2",        OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
    run_op("DIV -100/7",      OP_DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 34, 0);
    run_op("REM -100%7",      OP_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34, 0);
    run_op("DIVU 100/7",      OP_DIVU,   32'd100,      32'd7,        32'd14,       34, 0);

    // Flush at cycle 10 of a DIV: aborts, result keeps previous value (14)
    @(negedge clk);
    op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush result", result, 32'd14);
    dc = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dc++; end
    chk("flush no done", 32'(dc), 32'd0);
    chk("flush result later", result, 32'd14);

    // start and flush together in IDLE: not accepted
    @(negedge clk);
    op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start+flush busy", 32'(busy), 32'd0);
    dc = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dc++; end
    chk("start+flush no done", 32'(dc), 32'd0);
    chk("start+flush result", result, 32'd14);

    // Asynchronous reset mid-CALC clears outputs immediately
    @(negedge clk);
    op = OP_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    chk("async reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh op after reset, then a start held high while busy
    run_op("MUL after reset", OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    run_op("MULHU held start", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
